// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between the fetch (IF)
// and load/store (DM) ports. DM has priority. A starvation counter forces an
// IF grant after STARVE_MAX consecutive DM grants taken while IF waits.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE (one-cycle done
// pulse to the winner).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   if_req/if_addr         fetch request and address
//   if_rdata/if_done       fetched word and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata   data request, store flag, address, data
//   dm_rdata/dm_done       load result and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory interface
//   busy                   high whenever the arbiter is not idle
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
    logic [STV_W-1:0]   starve_cnt, starve_cnt_nxt;
    logic               win_dm, win_dm_nxt;
    logic               dm_wins;

    logic               mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt;
    logic [DATA_W-1:0]  if_rdata_nxt, dm_rdata_nxt;
    logic               if_done_nxt, dm_done_nxt, busy_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            win_dm     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            win_dm     <= win_dm_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            if_rdata   <= if_rdata_nxt;
            dm_rdata   <= dm_rdata_nxt;
            if_done    <= if_done_nxt;
            dm_done    <= dm_done_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state, arbitration and output values
    always_comb begin
        state_nxt      = state;
        lat_cnt_nxt    = lat_cnt;
        starve_cnt_nxt = starve_cnt;
        win_dm_nxt     = win_dm;
        dm_wins        = 1'b0;
        mem_en_nxt     = mem_en;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        if_rdata_nxt   = if_rdata;
        dm_rdata_nxt   = dm_rdata;
        if_done_nxt    = 1'b0;
        dm_done_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    // DM keeps priority until IF has been passed over STARVE_MAX times
                    dm_wins     = dm_req && (!if_req || (starve_cnt < STV_W'(STARVE_MAX)));
                    win_dm_nxt  = dm_wins;
                    state_nxt   = ST_ACCESS;
                    mem_en_nxt  = 1'b1;
                    lat_cnt_nxt = LAT_W'(MEM_LAT - 1);
                    if (dm_wins) begin
                        mem_we_nxt    = dm_we;
                        mem_addr_nxt  = dm_addr;
                        mem_wdata_nxt = dm_wdata;
                        if (!if_req) begin
                            starve_cnt_nxt = '0;
                        end else if (starve_cnt != STV_W'(STARVE_MAX)) begin
                            starve_cnt_nxt = starve_cnt + STV_W'(1);
                        end
                    end else begin
                        mem_we_nxt     = 1'b0;
                        mem_addr_nxt   = if_addr;
                        mem_wdata_nxt  = '0;
                        starve_cnt_nxt = '0;
                    end
                end
            end

            ST_ACCESS: begin
                if (lat_cnt == '0) begin
                    // Last access cycle: memory data is valid now
                    state_nxt     = ST_DONE;
                    mem_en_nxt    = 1'b0;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = '0;
                    mem_wdata_nxt = '0;
                    if (win_dm) begin
                        dm_done_nxt = 1'b1;
                        if (!mem_we) begin
                            dm_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_W'(1);
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned L    = 2;
    localparam int unsigned SMAX = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] if_rdata, dm_rdata;
    logic          if_done, dm_done;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    // Second instance with single-cycle memory, fetch port only
    logic          if_req_1;
    logic [AW-1:0] if_addr_1;
    logic [DW-1:0] if_rdata_1, dm_rdata_1;
    logic          if_done_1, dm_done_1;
    logic          mem_en_1, mem_we_1, busy_1;
    logic [AW-1:0] mem_addr_1;
    logic [DW-1:0] mem_wdata_1, mem_rdata_1;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_done(if_done_1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
        .dm_rdata(dm_rdata_1), .dm_done(dm_done_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .busy(busy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents before any store: word 4 (addr 0x10) is 0xDEADBEEF
    function automatic logic [31:0] pattern(input logic [5:0] i);
        return (i == 6'd4) ? 32'hDEADBEEF : (32'hC0DE0000 | {26'd0, i});
    endfunction

    bit [31:0] wmem [64];
    bit        written [64];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr[7:2]]    <= mem_wdata;
            written[mem_addr[7:2]] <= 1'b1;
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_en) begin
            mem_rdata = written[mem_addr[7:2]] ? wmem[mem_addr[7:2]] : pattern(mem_addr[7:2]);
        end
    end

    assign mem_rdata_1 = mem_en_1 ? pattern(mem_addr_1[7:2]) : '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
        if_req_1 = 0; if_addr_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({mem_en, mem_we, busy, if_done, dm_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_en, mem_we, busy, if_done, dm_done});
        end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_mem_bus got %h exp 0", {mem_addr, mem_wdata});
        end
        checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, dm_rdata});
        end
        checks++; if ({mem_en_1, busy_1} !== 2'b0) begin
            errors++; $display("FAIL reset_lat1 got %b exp 00", {mem_en_1, busy_1});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        if_addr = 32'h10; if_req = 1;
        tick();
        checks++; if ({mem_en, mem_we, busy, if_done} !== 4'b1010 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL fetch_grant got en/we/busy/done=%b addr=%h exp 1010 addr=10", {mem_en, mem_we, busy, if_done}, mem_addr);
        end
        tick();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || if_done !== 1'b0) begin
            errors++; $display("FAIL fetch_access2 got en=%b addr=%h done=%b exp 1 10 0", mem_en, mem_addr, if_done);
        end
        tick();
        checks++; if (mem_en !== 1'b0 || if_done !== 1'b1 || dm_done !== 1'b0) begin
            errors++; $display("FAIL fetch_done got en=%b if_done=%b dm_done=%b exp 0 1 0", mem_en, if_done, dm_done);
        end
        checks++; if (if_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_rdata got %h exp deadbeef", if_rdata);
        end
        if_req = 0;
        tick();
        checks++; if (if_done !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_after got done=%b busy=%b rdata=%h exp 0 0 deadbeef", if_done, busy, if_rdata);
        end
    endtask

    task automatic test_store();
        dm_addr = 32'h20; dm_wdata = 32'h1234; dm_we = 1; dm_req = 1;
        tick();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin
            errors++; $display("FAIL store_cyc1 got en=%b we=%b addr=%h wdata=%h", mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1234 || dm_done !== 1'b0) begin
            errors++; $display("FAIL store_cyc2 got we=%b wdata=%h done=%b exp 1 1234 0", mem_we, mem_wdata, dm_done);
        end
        tick();
        checks++; if (dm_done !== 1'b1 || if_done !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL store_done got dm_done=%b if_done=%b we=%b exp 1 0 0", dm_done, if_done, mem_we);
        end
        checks++; if (dm_rdata !== 32'h0) begin
            errors++; $display("FAIL store_rdata got %h exp 0", dm_rdata);
        end
        dm_req = 0; dm_we = 0;
        tick();
        checks++; if (dm_done !== 1'b0) begin
            errors++; $display("FAIL store_single_pulse got %b exp 0", dm_done);
        end
    endtask

    task automatic test_simultaneous();
        int dm_cyc = 0;
        int if_cyc = 0;
        if_addr = 32'h20; dm_addr = 32'h10; dm_we = 0;
        if_req = 1; dm_req = 1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            if (cyc == 1) begin
                checks++; if (mem_addr !== 32'h10) begin
                    errors++; $display("FAIL simul_dm_first got addr %h exp 10", mem_addr);
                end
            end
            if (if_done && dm_done) begin
                checks++; errors++; $display("FAIL simul_both_done got 11 exp exclusive");
            end
            if (dm_done) begin dm_cyc = cyc; dm_req = 0; end
            if (if_done) begin if_cyc = cyc; if_req = 0; break; end
        end
        checks++; if (dm_cyc !== 3) begin
            errors++; $display("FAIL simul_dm_cycle got %0d exp 3", dm_cyc);
        end
        checks++; if (if_cyc - dm_cyc !== 4) begin
            errors++; $display("FAIL simul_if_gap got %0d exp 4", if_cyc - dm_cyc);
        end
        checks++; if (if_rdata !== 32'h1234 || dm_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL simul_rdata got if=%h dm=%h exp 1234 deadbeef", if_rdata, dm_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        int n = 0;
        logic prev_en = 1'b0;
        logic exp_if;
        if_addr = 32'h40; dm_addr = 32'h80; dm_we = 0;
        if_req = 1; dm_req = 1;
        for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
            tick();
            if (mem_en && !prev_en) begin
                exp_if = ((n % 5) == 4);
                checks++; if ((mem_addr == 32'h40) !== exp_if) begin
                    errors++; $display("FAIL starve_grant%0d got addr %h exp %s", n, mem_addr, exp_if ? "IF" : "DM");
                end
                n++;
            end
            prev_en = mem_en;
        end
        checks++; if (n !== 10) begin
            errors++; $display("FAIL starve_grant_count got %0d exp 10", n);
        end
        if_req = 0; dm_req = 0;
        for (int i = 0; i < 10 && busy; i++) tick();
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL starve_drain got busy %b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        if_addr = 32'h10; if_req = 1;
        tick();
        tick();
        checks++; if (mem_en !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got en %b exp 1", mem_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mem_en, busy, if_done, dm_done} !== 4'b0 || if_rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_async got ctrl=%b rdata=%h exp 0000 0", {mem_en, busy, if_done, dm_done}, if_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (mem_en !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL rstmid_regrant got en=%b busy=%b addr=%h exp 1 1 10", mem_en, busy, mem_addr);
        end
        tick();
        tick();
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rstmid_done got done=%b rdata=%h exp 1 deadbeef", if_done, if_rdata);
        end
        if_req = 0;
        tick();
    endtask

    task automatic test_lat1();
        int k = 0;
        int last = 0;
        if_addr_1 = 32'h0; if_req_1 = 1;
        for (int cyc = 1; cyc <= 30 && k < 3; cyc++) begin
            tick();
            if (if_done_1) begin
                checks++; if (if_rdata_1 !== pattern(6'(k))) begin
                    errors++; $display("FAIL lat1_rdata%0d got %h exp %h", k, if_rdata_1, pattern(6'(k)));
                end
                checks++; if ((k == 0 && cyc != 2) || (k > 0 && cyc - last != 3)) begin
                    errors++; $display("FAIL lat1_timing%0d got cycle %0d prev %0d", k, cyc, last);
                end
                checks++; if ({dm_done_1, mem_we_1, mem_en_1} !== 3'b0 || dm_rdata_1 !== '0 || {mem_addr_1, mem_wdata_1} !== 64'h0) begin
                    errors++; $display("FAIL lat1_idle_side got %b exp 000", {dm_done_1, mem_we_1, mem_en_1});
                end
                last = cyc;
                k++;
                if_addr_1 = 32'(k * 4);
                if (k == 3) if_req_1 = 0;
            end
        end
        checks++; if (k !== 3) begin
            errors++; $display("FAIL lat1_count got %0d exp 3", k);
        end
        tick();
        checks++; if (busy_1 !== 1'b0) begin
            errors++; $display("FAIL lat1_busy got %b exp 0", busy_1);
        end
    endtask

    // Transaction-level model: a grant at edge g occupies edges g..g+L+1,
    // with data and done at edge g+L; next IDLE sample is edge g+L+2.
    task automatic test_random();
        int e = 0, g = 0, free_at = 0, starve = 0;
        bit have = 0, t_dm = 0, t_we = 0, exp_en, exp_done, exp_busy;
        logic [31:0] t_addr = 0, t_wdata = 0, m_if = 0, m_dm = 0;
        logic [31:0] m_mem [64];
        for (int i = 0; i < 64; i++) m_mem[i] = pattern(6'(i));
        m_mem[8] = 32'h1234;
        if_req = 0; dm_req = 0; dm_we = 0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            e++;
            if (e >= free_at && (if_req || dm_req)) begin
                t_dm = dm_req && (!if_req || starve < int'(SMAX));
                if (t_dm) begin
                    t_we = dm_we; t_addr = dm_addr; t_wdata = dm_wdata;
                    starve = if_req ? ((starve < int'(SMAX)) ? starve + 1 : starve) : 0;
                end else begin
                    t_we = 0; t_addr = if_addr; t_wdata = 0; starve = 0;
                end
                g = e; free_at = e + int'(L) + 2; have = 1;
            end
            exp_en   = have && (e < g + int'(L));
            exp_done = have && (e == g + int'(L));
            exp_busy = have && (e <= g + int'(L));
            if (exp_done) begin
                if (!t_dm)     m_if = m_mem[t_addr[7:2]];
                else if (!t_we) m_dm = m_mem[t_addr[7:2]];
                else           m_mem[t_addr[7:2]] = t_wdata;
            end
            checks++; if (mem_en !== exp_en || busy !== exp_busy) begin
                errors++; $display("FAIL rnd_en_busy e=%0d got %b%b exp %b%b", e, mem_en, busy, exp_en, exp_busy);
            end
            checks++; if (mem_we !== (exp_en && t_we) || mem_addr !== (exp_en ? t_addr : 32'h0) || mem_wdata !== (exp_en ? t_wdata : 32'h0)) begin
                errors++; $display("FAIL rnd_mem_bus e=%0d got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h", e, mem_we, mem_addr, mem_wdata,
                                   exp_en && t_we, exp_en ? t_addr : 32'h0, exp_en ? t_wdata : 32'h0);
            end
            checks++; if (if_done !== (exp_done && !t_dm) || dm_done !== (exp_done && t_dm)) begin
                errors++; $display("FAIL rnd_done e=%0d got if=%b dm=%b exp if=%b dm=%b", e, if_done, dm_done, exp_done && !t_dm, exp_done && t_dm);
            end
            checks++; if (if_rdata !== m_if || dm_rdata !== m_dm) begin
                errors++; $display("FAIL rnd_rdata e=%0d got if=%h dm=%h exp if=%h dm=%h", e, if_rdata, dm_rdata, m_if, m_dm);
            end
            // Requester agents: drop or renew after done, otherwise raise randomly
            if (exp_done && !t_dm) begin
                if ($urandom_range(0, 2) == 0) if_addr = 32'($urandom_range(0, 63)) << 2;
                else if_req = 0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (exp_done && t_dm) begin
                if ($urandom_range(0, 2) == 0) begin
                    dm_addr = 32'($urandom_range(0, 63)) << 2; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
                end else dm_req = 0;
            end else if (!dm_req && $urandom_range(0, 1) == 0) begin
                dm_req = 1; dm_addr = 32'($urandom_range(0, 63)) << 2;
                dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
